yoshi_jump_fsm: RTL and testbench

Vertical-motion controller for the yoshi sprite. It owns the sprite's y coordinate and the jump state machine: standing, ascending and descending. It drives y_y and jumping_up into the grounded-detection stage and consumes that stage's registered grounded output to end a fall or to detect walking off a platform edge. Its y_y output also feeds the sprite/VGA pixel-generation logic.

---
 rtl/yoshi_jump_fsm_if.sv | 28 ++
 rtl/yoshi_jump_fsm.sv | 156 +++++++++++++++
 tb/tb_yoshi_jump_fsm.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yoshi_jump_fsm_if.sv
// ============================================================================
// Module      : yoshi_jump_fsm_if
// Description : Signal bundle between the yoshi vertical-motion FSM and its
//               environment (button, grounded detector, pixel generation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface yoshi_jump_fsm_if;
    logic       jump_btn;
    logic       grounded;
    logic [9:0] y_y;
    logic       jumping_up;
    logic [1:0] jump_state;
    logic [9:0] apex_y;

    modport master (
        output jump_btn, grounded,
        input  y_y, jumping_up, jump_state, apex_y
    );

    modport slave (
        input  jump_btn, grounded,
        output y_y, jumping_up, jump_state, apex_y
    );
endinterface

`default_nettype wire

// File: rtl/yoshi_jump_fsm.sv
// ============================================================================
// Module      : yoshi_jump_fsm
// Description : Yoshi sprite y coordinate and jump FSM (IDLE / UP / DOWN).
//               Optional macro VAR_JUMP_EN: releasing the button cuts the
//               ascent short (variable-height hop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module yoshi_jump_fsm #(
    parameter int unsigned Y_START          = 432,
    parameter int unsigned JUMP_HEIGHT      = 64,
    parameter int unsigned UP_DELAY_START   = 250000,
    parameter int unsigned UP_DELAY_MAX     = 800000,
    parameter int unsigned DOWN_DELAY_START = 800000,
    parameter int unsigned DOWN_DELAY_MIN   = 250000,
    parameter int unsigned DELAY_STEP       = 2500,
    parameter int unsigned TW               = 20
) (
    input  wire logic        clk,
    input  wire logic        reset,
    yoshi_jump_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic [9:0]    c_Y_START    = 10'(Y_START);
    localparam logic [9:0]    c_JUMP_H     = 10'(JUMP_HEIGHT);
    localparam logic [9:0]    c_APEX_RST   = (Y_START >= JUMP_HEIGHT) ? 10'(Y_START - JUMP_HEIGHT) : 10'd0;
    localparam logic [TW-1:0] c_UP_START   = TW'(UP_DELAY_START);
    localparam logic [TW-1:0] c_UP_MAX     = TW'(UP_DELAY_MAX);
    localparam logic [TW-1:0] c_DN_START   = TW'(DOWN_DELAY_START);
    localparam logic [TW-1:0] c_DN_MIN     = TW'(DOWN_DELAY_MIN);
    localparam logic [TW-1:0] c_STEP       = TW'(DELAY_STEP);
    localparam logic [TW:0]   c_STEP_W     = (TW+1)'(DELAY_STEP);
    localparam logic [TW:0]   c_DEC_FLOOR  = (TW+1)'(DOWN_DELAY_MIN) + (TW+1)'(DELAY_STEP);

    state_t        r_state;
    logic [9:0]    r_y;
    logic [9:0]    r_apex;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] r_delay;
    logic          r_btn_q;
    logic          r_jumping_up;

    logic          w_press;
    logic          w_step;
    logic [9:0]    w_y_dec;
    logic [9:0]    w_y_inc;
    logic [9:0]    w_apex;
    logic [TW:0]   w_delay_sum;
    logic [TW-1:0] w_delay_inc;
    logic [TW-1:0] w_delay_dec;
    logic          w_up_done;
    logic          w_release;

`ifdef VAR_JUMP_EN
    assign w_release = ~bus.jump_btn;
`else
    assign w_release = 1'b0;
`endif

    // Saturating arithmetic: y never wraps, delay clamps at both ends.
    always_comb begin
        w_press     = bus.jump_btn & ~r_btn_q;
        w_step      = (r_timer == (r_delay - 1'b1));
        w_y_dec     = (r_y == 10'd0) ? 10'd0 : r_y - 10'd1;
        w_y_inc     = (r_y >= c_Y_START) ? c_Y_START : r_y + 10'd1;
        w_apex      = (r_y >= c_JUMP_H) ? r_y - c_JUMP_H : 10'd0;
        w_delay_sum = {1'b0, r_delay} + c_STEP_W;
        w_delay_inc = w_delay_sum[TW] ? {TW{1'b1}} : w_delay_sum[TW-1:0];
        w_delay_dec = ({1'b0, r_delay} >= c_DEC_FLOOR) ? r_delay - c_STEP : c_DN_MIN;
        w_up_done   = (w_y_dec == r_apex) || (w_y_dec == 10'd0) || (w_delay_inc >= c_UP_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_y          <= c_Y_START;
            r_apex       <= c_APEX_RST;
            r_timer      <= '0;
            r_delay      <= '0;
            r_btn_q      <= 1'b0;
            r_jumping_up <= 1'b0;
        end else begin
            r_btn_q <= bus.jump_btn;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (!bus.grounded) begin
                        r_state <= ST_DOWN;
                        r_delay <= c_DN_START;
                    end else if (w_press) begin
                        r_state      <= ST_UP;
                        r_delay      <= c_UP_START;
                        r_apex       <= w_apex;
                        r_jumping_up <= 1'b1;
                    end
                end
                ST_UP: begin
                    // A step due on the release edge is applied before falling.
                    if (w_step) begin
                        r_y     <= w_y_dec;
                        r_timer <= '0;
                        if (w_up_done || w_release) begin
                            r_state      <= ST_DOWN;
                            r_delay      <= c_DN_START;
                            r_jumping_up <= 1'b0;
                        end else begin
                            r_delay <= w_delay_inc;
                        end
                    end else if (w_release) begin
                        r_state      <= ST_DOWN;
                        r_timer      <= '0;
                        r_delay      <= c_DN_START;
                        r_jumping_up <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (bus.grounded) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else if (w_step) begin
                        r_y     <= w_y_inc;
                        r_timer <= '0;
                        r_delay <= w_delay_dec;
                        if (w_y_inc == c_Y_START) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_timer      <= '0;
                    r_jumping_up <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y_y        = r_y;
    assign bus.apex_y     = r_apex;
    assign bus.jumping_up = r_jumping_up;
    assign bus.jump_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_yoshi_jump_fsm.sv
// ============================================================================
// Module      : tb_yoshi_jump_fsm
// Description : Scoreboard bench for yoshi_jump_fsm: expected pixel steps
//               (row, edge number) are queued per jump and checked as y moves.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yoshi_jump_fsm;

    localparam int FLOOR  = 432;
    localparam int CEIL_Y = 5;
    localparam int JH     = 8;
    localparam int UP_S   = 4;
    localparam int UP_MAX = 40;
    localparam int DN_S   = 40;
    localparam int DN_MIN = 4;
    localparam int STEP   = 4;
`ifdef VAR_JUMP_EN
    localparam bit VAR_EN = 1'b1;
`else
    localparam bit VAR_EN = 1'b0;
`endif

    typedef struct {
        int y;
        int at;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   plat_row = 0;
    int   total = 0;
    int   bad = 0;
    step_t q0[$];
    step_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    yoshi_jump_fsm_if bus ();
    yoshi_jump_fsm_if busc ();

    yoshi_jump_fsm #(
        .Y_START(FLOOR), .JUMP_HEIGHT(JH), .UP_DELAY_START(UP_S), .UP_DELAY_MAX(UP_MAX),
        .DOWN_DELAY_START(DN_S), .DOWN_DELAY_MIN(DN_MIN), .DELAY_STEP(STEP), .TW(20)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    yoshi_jump_fsm #(
        .Y_START(CEIL_Y), .JUMP_HEIGHT(JH), .UP_DELAY_START(UP_S), .UP_DELAY_MAX(UP_MAX),
        .DOWN_DELAY_START(DN_S), .DOWN_DELAY_MIN(DN_MIN), .DELAY_STEP(STEP), .TW(20)
    ) dut_ceil (
        .clk(clk), .reset(reset), .bus(busc)
    );

    // Registered grounded detectors: floor row plus one optional platform row.
    always @(posedge clk or posedge reset) begin
        if (reset) bus.grounded <= 1'b1;
        else       bus.grounded <= (bus.y_y == 10'(FLOOR)) || (plat_row != 0 && int'(bus.y_y) == plat_row);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) busc.grounded <= 1'b1;
        else       busc.grounded <= (busc.y_y == 10'(CEIL_Y));
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int which, input int y, input int at);
        step_t s;
        s.y  = y;
        s.at = at;
        if (which == 0) q0.push_back(s);
        else            q1.push_back(s);
    endtask

    // Ascent: the n-th pixel takes UP_S+(n-1)*STEP cycles; stops at apex,
    // row 0, or once the next delay would reach UP_MAX. Release adds one edge.
    task automatic model_up(input int which, input int y0, input int t0, input int rel_after,
                            output int y, output int t);
        int d;
        int apex;
        int n;
        d    = UP_S;
        apex = (y0 >= JH) ? y0 - JH : 0;
        n    = 0;
        y    = y0;
        t    = t0;
        forever begin
            t += d;
            y -= 1;
            n++;
            push(which, y, t);
            d += STEP;
            if (y == apex || y == 0 || d >= UP_MAX) break;
            if (VAR_EN && n == rel_after) begin
                t += 1;
                break;
            end
        end
    endtask

    // Descent: delays DN_S, DN_S-STEP, ... floored at DN_MIN until a platform or floor.
    task automatic model_down(input int which, input int y0, input int t0, input int stop_row,
                              input int floor_y);
        int d;
        int y;
        int t;
        d = DN_S;
        y = y0;
        t = t0;
        while (y != stop_row && y < floor_y) begin
            t += d;
            y += 1;
            push(which, y, t);
            d = (d - STEP < DN_MIN) ? DN_MIN : d - STEP;
        end
    endtask

    task automatic pop_check(input int which, input int y);
        step_t e;
        if ((which == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("unexpected_step%0d", which), y, -1);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("step%0d_y", which), y, e.y);
            check($sformatf("step%0d_edge", which), cyc, e.at);
        end
    endtask

    // Monitor: every change of y is one pixel step and must match the queue head.
    initial begin
        logic [9:0] prev0;
        logic [9:0] prev1;
        prev0 = 10'(FLOOR);
        prev1 = 10'(CEIL_Y);
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev0 = bus.y_y;
                prev1 = busc.y_y;
            end else begin
                if (bus.y_y != prev0) begin
                    pop_check(0, int'(bus.y_y));
                    prev0 = bus.y_y;
                end
                if (busc.y_y != prev1) begin
                    pop_check(1, int'(busc.y_y));
                    prev1 = busc.y_y;
                end
            end
        end
    end

    task automatic drain(input int which, input string name, input int budget);
        int k;
        k = 0;
        while ((which == 0 ? q0.size() : q1.size()) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, (which == 0 ? q0.size() : q1.size()), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic jump_main(input int rel_after, input int stop_row, input string name);
        int y0;
        int y;
        int t;
        int k;
        y0 = int'(bus.y_y);
        model_up(0, y0, cyc + 1, rel_after, y, t);
        model_down(0, y, t, stop_row, FLOOR);
        bus.jump_btn = 1'b1;
        @(negedge clk);
        check({name, "_jumping_up"}, bus.jumping_up, 1);
        check({name, "_state_up"}, bus.jump_state, 1);
        check({name, "_apex"}, bus.apex_y, (y0 >= JH) ? y0 - JH : 0);
        if (rel_after > 0) begin
            k = 0;
            while (int'(bus.y_y) != y0 - rel_after && k < 500) begin
                @(negedge clk);
                k++;
            end
            check({name, "_release_row"}, bus.y_y, y0 - rel_after);
            bus.jump_btn = 1'b0;
        end
        drain(0, name, 800);
        check({name, "_idle"}, bus.jump_state, 0);
    endtask

    initial begin
        int k;
        int y;
        int t;
        bus.jump_btn  = 1'b0;
        busc.jump_btn = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_y", bus.y_y, FLOOR);
        check("rst_state", bus.jump_state, 0);
        check("rst_jumping_up", bus.jumping_up, 0);
        check("rst_apex", bus.apex_y, FLOOR - JH);
        check("rst_ceil_y", busc.y_y, CEIL_Y);
        check("rst_ceil_apex", busc.apex_y, 0);
        repeat ($urandom_range(2, 9)) @(negedge clk);

        // Full jump with the button held through landing: no retrigger.
        jump_main(-1, -1, "full");
        check("full_land_y", bus.y_y, FLOOR);
        repeat (30) @(negedge clk);
        check("held_no_retrigger", bus.jump_state, 0);
        check("held_y", bus.y_y, FLOOR);
        bus.jump_btn = 1'b0;
        repeat ($urandom_range(2, 9)) @(negedge clk);

        // Land on a platform at the apex row, then climb to a higher one.
        plat_row = 424;
        jump_main(-1, 424, "plat1");
        check("plat1_y", bus.y_y, 424);
        bus.jump_btn = 1'b0;
        repeat ($urandom_range(2, 9)) @(negedge clk);
        plat_row = 416;
        jump_main(-1, 416, "plat2");
        check("plat2_y", bus.y_y, 416);
        bus.jump_btn = 1'b0;
        repeat ($urandom_range(2, 9)) @(negedge clk);

        // Walk off 416, long enough fall to hit the terminal delay, land on 428.
        plat_row = 428;
        model_down(0, 416, cyc + 2, 428, FLOOR);
        repeat (2) @(negedge clk);
        check("walkoff_state", bus.jump_state, 2);
        check("walkoff_jumping_up", bus.jumping_up, 0);
        drain(0, "walkoff", 800);
        check("walkoff_idle", bus.jump_state, 0);
        check("walkoff_y", bus.y_y, 428);
        plat_row = 0;
        model_down(0, 428, cyc + 2, -1, FLOOR);
        drain(0, "walkoff2", 400);
        check("walkoff2_y", bus.y_y, FLOOR);
        repeat ($urandom_range(2, 9)) @(negedge clk);

        // Asynchronous reset during the descent at row 428.
        model_up(0, FLOOR, cyc + 1, -1, y, t);
        model_down(0, y, t, -1, FLOOR);
        bus.jump_btn = 1'b1;
        k = 0;
        while (!(bus.jump_state == 2'd2 && bus.y_y == 10'd428) && k < 800) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reached", bus.y_y, 428);
        q0.delete();
        reset = 1'b1;
        #1;
        check("rstmid_y", bus.y_y, FLOOR);
        check("rstmid_state", bus.jump_state, 0);
        check("rstmid_jumping_up", bus.jumping_up, 0);
        check("rstmid_apex", bus.apex_y, FLOOR - JH);
        @(negedge clk);
        bus.jump_btn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat ($urandom_range(2, 9)) @(negedge clk);

        // Release after two up-steps: short hop only with VAR_JUMP_EN.
        jump_main(2, -1, "hop");
        check("hop_land_y", bus.y_y, FLOOR);
        repeat ($urandom_range(2, 9)) @(negedge clk);

        // Ceiling: from row 5 the ascent must stop at 0 without wrapping.
        model_up(1, CEIL_Y, cyc + 1, -1, y, t);
        model_down(1, y, t, -1, CEIL_Y);
        busc.jump_btn = 1'b1;
        @(negedge clk);
        check("ceil_state_up", busc.jump_state, 1);
        drain(1, "ceil", 800);
        check("ceil_idle", busc.jump_state, 0);
        check("ceil_y", busc.y_y, CEIL_Y);
        busc.jump_btn = 1'b0;

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(2, 12)) @(negedge clk);
            jump_main(int'($urandom_range(1, 7)), -1, "rand");
            check("rand_land_y", bus.y_y, FLOOR);
            bus.jump_btn = 1'b0;
        end

        repeat (10) @(negedge clk);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got edge %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
